// File: rtl/rl_pair_scheduler_pkg.sv
// Shared definitions for the range-limited pair scheduler: FSM state encoding
// and the default BRAM address width also used by the position BRAM wrappers.
package rl_pair_scheduler_pkg;

  localparam int RL_ADDR_WIDTH_DEFAULT = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rl_state_e;

endpackage

// File: rtl/rl_pair_scheduler_valid_delay.sv
// 1-bit valid shift register matching the BRAM read latency; any_valid flags
// reads still in flight so the scheduler can hold off its end-of-job pulse.
module rl_pair_scheduler_valid_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic out_valid,
  output logic any_valid
);

  logic [DEPTH-1:0] stage_r;

  // Shift the issue strobe down the pipe; reset empties every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_r <= '0;
    end else begin
      stage_r[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign out_valid = stage_r[DEPTH-1];
  assign any_valid = |stage_r;

endmodule

// File: rtl/rl_pair_scheduler.sv
// Pair-issue controller for one range-limited force pipeline: walks home x
// neighbour indices, drives BRAM reads, tracks in-flight forces, pulses done.
module rl_pair_scheduler
  import rl_pair_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH      = RL_ADDR_WIDTH_DEFAULT,
  parameter int RAM_LATENCY     = 1,
  parameter int MAX_OUTSTANDING = 64,
  parameter int OUT_WIDTH       = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH:0]     home_count,
  input  logic [ADDR_WIDTH:0]     nbr_count,
  input  logic                    skip_self,
  input  logic                    pair_ready,
  input  logic                    force_valid,
  output logic [ADDR_WIDTH-1:0]   home_rdaddr,
  output logic [ADDR_WIDTH-1:0]   nbr_rdaddr,
  output logic                    rden,
  output logic                    pair_valid,
  output logic                    busy,
  output logic                    done,
  output logic [2*ADDR_WIDTH+1:0] pair_count,
  output logic                    err_underflow
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int PW = 2 * ADDR_WIDTH + 2;

  rl_state_e             state_r;
  logic [ADDR_WIDTH-1:0] home_r, nbr_r;
  logic [CW-1:0]         home_cnt_r, nbr_cnt_r;
  logic                  skip_r, err_r;
  logic [OUT_WIDTH-1:0]  outstanding_r;
  logic [PW-1:0]         pair_count_r;

  logic self_s, room_s, issue_s, advance_s, last_nbr_s, last_home_s;
  logic start_acc_s, underflow_s, delay_any_s;

  // Issue decision: a skipped self-pair still advances the walk, a stall does not.
  always_comb begin
    self_s      = skip_r & (home_r == nbr_r);
    room_s      = (outstanding_r < OUT_WIDTH'(MAX_OUTSTANDING));
    last_nbr_s  = ({1'b0, nbr_r} == (nbr_cnt_r - CW'(1)));
    last_home_s = ({1'b0, home_r} == (home_cnt_r - CW'(1)));
    start_acc_s = (state_r == ST_IDLE) & start;
    if (state_r == ST_ISSUE) begin
      issue_s   = pair_ready & room_s & ~self_s;
      advance_s = issue_s | self_s;
    end else begin
      issue_s   = 1'b0;
      advance_s = 1'b0;
    end
    underflow_s = force_valid & ~issue_s & (outstanding_r == '0);
  end

  // Job FSM and index walk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      home_r     <= '0;
      nbr_r      <= '0;
      home_cnt_r <= '0;
      nbr_cnt_r  <= '0;
      skip_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            home_cnt_r <= home_count;
            nbr_cnt_r  <= nbr_count;
            skip_r     <= skip_self;
            home_r     <= '0;
            nbr_r      <= '0;
            state_r    <= ((home_count == '0) || (nbr_count == '0)) ? ST_DRAIN : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (advance_s) begin
            if (last_nbr_s) begin
              if (last_home_s) begin
                state_r <= ST_DRAIN;
              end else begin
                nbr_r  <= '0;
                home_r <= home_r + ADDR_WIDTH'(1);
              end
            end else begin
              nbr_r <= nbr_r + ADDR_WIDTH'(1);
            end
          end
        end
        ST_DRAIN: begin
          if ((outstanding_r == '0) && !delay_any_s) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE:  state_r <= ST_IDLE;
        default:  state_r <= ST_IDLE;
      endcase
    end
  end

  // In-flight force tracking, issued-pair count and sticky underflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_r <= '0;
      pair_count_r  <= '0;
      err_r         <= 1'b0;
    end else begin
      case ({issue_s, force_valid})
        2'b10:   outstanding_r <= outstanding_r + OUT_WIDTH'(1);
        2'b01:   outstanding_r <= (outstanding_r == '0) ? outstanding_r : outstanding_r - OUT_WIDTH'(1);
        default: outstanding_r <= outstanding_r;
      endcase
      if (start_acc_s) begin
        pair_count_r <= '0;
      end else if (issue_s && (pair_count_r != '1)) begin
        pair_count_r <= pair_count_r + PW'(1);
      end
      if (start_acc_s) begin
        err_r <= 1'b0;
      end else if (underflow_s) begin
        err_r <= 1'b1;
      end
    end
  end

  rl_pair_scheduler_valid_delay #(
    .DEPTH (RAM_LATENCY)
  ) u_valid_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue_s),
    .out_valid (pair_valid),
    .any_valid (delay_any_s)
  );

  assign rden          = issue_s;
  assign home_rdaddr   = home_r;
  assign nbr_rdaddr    = nbr_r;
  assign busy          = (state_r == ST_ISSUE) || (state_r == ST_DRAIN);
  assign done          = (state_r == ST_DONE);
  assign pair_count    = pair_count_r;
  assign err_underflow = err_r;

endmodule

// File: tb/tb_rl_pair_scheduler.sv
// Directed scoreboard bench for rl_pair_scheduler: expected pair addresses are
// queued at job start and popped on every rden; forces are echoed back.
module tb_rl_pair_scheduler;

  localparam int AW   = 9;
  localparam int LAT  = 2;
  localparam int MAXO = 4;

  logic              clk = 1'b0;
  logic              rst, start, skip_self, pair_ready, force_valid;
  logic [AW:0]       home_count, nbr_count;
  logic [AW-1:0]     home_rdaddr, nbr_rdaddr;
  logic              rden, pair_valid, busy, done, err_underflow;
  logic [2*AW+1:0]   pair_count;

  rl_pair_scheduler #(
    .ADDR_WIDTH (AW), .RAM_LATENCY (LAT), .MAX_OUTSTANDING (MAXO), .OUT_WIDTH (3)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .home_count (home_count),
    .nbr_count (nbr_count), .skip_self (skip_self), .pair_ready (pair_ready),
    .force_valid (force_valid), .home_rdaddr (home_rdaddr), .nbr_rdaddr (nbr_rdaddr),
    .rden (rden), .pair_valid (pair_valid), .busy (busy), .done (done),
    .pair_count (pair_count), .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int cyc = 0, rden_cnt = 0, done_cnt = 0, done_cyc = 0, last_force_cyc = 0;
  logic [2*AW-1:0] exp_q[$];
  int due_q[$];
  logic echo_en = 1'b0, fv_manual = 1'b0, rst_q = 1'b1, h0 = 1'b0, h1 = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  // Monitor: scoreboard pop on rden, latency alignment of pair_valid, force echo scheduling.
  always @(negedge clk) begin
    logic [2*AW-1:0] e;
    if (rden) begin
      rden_cnt++;
      if (exp_q.size() == 0) begin
        check("rden_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("pair_addr", {home_rdaddr, nbr_rdaddr}, e);
      end
    end
    check("pair_valid_align", pair_valid, rst_q ? 1'b0 : h1);
    h1 = h0;
    h0 = rden;
    if (rst_q) begin
      h1 = 1'b0;
      h0 = 1'b0;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (pair_valid && echo_en) due_q.push_back(cyc + 20);
  end

  // Force return path: echoed forces plus manual pulses from the main sequence.
  initial begin
    logic hit;
    force_valid = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      hit = 1'b0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        hit = 1'b1;
        last_force_cyc = cyc;
      end
      force_valid = hit | fv_manual;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_pairs(input int h, input int n, input logic s);
    logic [AW-1:0] hi, ni;
    for (int i = 0; i < h; i++)
      for (int j = 0; j < n; j++)
        if (!(s && i == j)) begin
          hi = AW'(i);
          ni = AW'(j);
          exp_q.push_back({hi, ni});
        end
  endtask

  task automatic start_job(input int h, input int n, input logic s);
    home_count = (AW+1)'(h);
    nbr_count  = (AW+1)'(n);
    skip_self  = s;
    start      = 1'b1;
    tick(1);
    start      = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string tag);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, done_cnt - d0, 1);
  endtask

  initial begin
    int d0, r0, forces;
    rst = 1'b1; start = 1'b0; skip_self = 1'b0; pair_ready = 1'b0;
    home_count = '0; nbr_count = '0;
    tick(3);
    check("rst_rden", rden, 0);
    check("rst_pair_valid", pair_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", {home_rdaddr, nbr_rdaddr}, 0);
    check("rst_pair_count", pair_count, 0);
    check("rst_err", err_underflow, 0);
    rst = 1'b0;
    tick(2);

    // 3x4 full walk with echoed forces
    echo_en = 1'b1; pair_ready = 1'b1;
    d0 = done_cnt; r0 = rden_cnt;
    push_pairs(3, 4, 1'b0);
    start_job(3, 4, 1'b0);
    check("t1_busy", busy, 1);
    wait_done(d0, 600, "t1_done");
    check("t1_rden_count", rden_cnt - r0, 12);
    check("t1_pair_count", pair_count, 12);
    check("t1_done_after_force", done_cyc > last_force_cyc, 1);
    check("t1_queue_empty", exp_q.size(), 0);
    tick(5);
    check("t1_done_once", done_cnt - d0, 1);
    check("t1_idle", busy, 0);

    // 4x4 with self-pairs skipped
    d0 = done_cnt; r0 = rden_cnt;
    push_pairs(4, 4, 1'b1);
    start_job(4, 4, 1'b1);
    wait_done(d0, 600, "t2_done");
    check("t2_rden_count", rden_cnt - r0, 12);
    check("t2_pair_count", pair_count, 12);
    tick(5);
    check("t2_done_once", done_cnt - d0, 1);

    // 2x2 with ready 1,0,0,1
    pair_ready = 1'b0;
    d0 = done_cnt; r0 = rden_cnt;
    push_pairs(2, 2, 1'b0);
    start_job(2, 2, 1'b0);
    pair_ready = 1'b1; #1;
    check("t3_s0_rden", rden, 1);
    check("t3_s0_addr", {home_rdaddr, nbr_rdaddr}, {9'd0, 9'd0});
    tick(1); pair_ready = 1'b0; #1;
    check("t3_s1_rden", rden, 0);
    check("t3_s1_addr", {home_rdaddr, nbr_rdaddr}, {9'd0, 9'd1});
    tick(1); #1;
    check("t3_s2_rden", rden, 0);
    check("t3_s2_addr", {home_rdaddr, nbr_rdaddr}, {9'd0, 9'd1});
    tick(1); pair_ready = 1'b1; #1;
    check("t3_s3_rden", rden, 1);
    check("t3_s3_addr", {home_rdaddr, nbr_rdaddr}, {9'd0, 9'd1});
    wait_done(d0, 300, "t3_done");
    check("t3_rden_count", rden_cnt - r0, 4);

    // outstanding limit: no returns for 50 cycles
    echo_en = 1'b0;
    d0 = done_cnt; r0 = rden_cnt;
    push_pairs(3, 3, 1'b0);
    start_job(3, 3, 1'b0);
    tick(50);
    check("t4_stall_count", rden_cnt - r0, MAXO);
    check("t4_stall_rden", rden, 0);
    check("t4_stall_busy", busy, 1);
    forces = 0;
    repeat (4) begin
      fv_manual = 1'b1; forces++;
      tick(1);
      fv_manual = 1'b0;
      tick(2);
    end
    tick(3);
    check("t4_released", rden_cnt - r0, 2 * MAXO);
    for (int k = 0; k < 80 && done_cnt == d0; k++) begin
      if (rden_cnt - r0 > forces) begin
        fv_manual = 1'b1;
        forces++;
      end else begin
        fv_manual = 1'b0;
      end
      tick(1);
    end
    fv_manual = 1'b0;
    check("t4_done", done_cnt - d0, 1);
    check("t4_pair_count", pair_count, 9);
    check("t4_forces", forces, 9);
    check("t4_no_underflow", err_underflow, 0);

    // empty job
    echo_en = 1'b1;
    d0 = done_cnt; r0 = rden_cnt;
    start_job(0, 5, 1'b0);
    wait_done(d0, 3, "t5_done_fast");
    check("t5_no_rden", rden_cnt - r0, 0);
    check("t5_pair_count", pair_count, 0);

    // reset mid-ISSUE on 8x8
    d0 = done_cnt;
    push_pairs(8, 8, 1'b0);
    start_job(8, 8, 1'b0);
    tick(10);
    rst = 1'b1;
    tick(1);
    check("t6_rden", rden, 0);
    check("t6_pair_valid", pair_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_addr", {home_rdaddr, nbr_rdaddr}, 0);
    check("t6_pair_count", pair_count, 0);
    exp_q.delete();
    due_q.delete();
    echo_en = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(3);
    check("t6_no_done", done_cnt - d0, 0);
    check("t6_err_clear", err_underflow, 0);
    fv_manual = 1'b1;
    tick(1);
    fv_manual = 1'b0;
    tick(2);
    check("t6_underflow", err_underflow, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
